// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial scan controller.
// Optional position reporting is enabled with SEQ_SCAN_POS_EN (see seq_scan_ctrl).
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_PAT_W  = 3;
    localparam int DEF_CNT_W  = 8;

    // All-ones value of a w-bit unsigned counter (w <= 32).
    function automatic int unsigned sat_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pattern_mealy_fsm.sv
// Programmable Mealy detector: compares the last PAT_W serial bits
// (newest in bit 0) against a stored pattern; overlapping matches allowed.
module pattern_mealy_fsm
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             clr,
    input  logic             load,
    input  logic [PAT_W-1:0] pat,
    output logic             z
);

    localparam int HC_W = $clog2(PAT_W);
    localparam logic [HC_W-1:0] HIST_FULL = HC_W'(PAT_W - 1);

    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [HC_W-1:0]  hcnt_q, hcnt_d;
    logic [PAT_W-1:0] window;

    // Window = stored history plus the bit arriving this cycle.
    assign window = {hist_q, x};

    // Match output and next history/pattern; history fills before matching is allowed.
    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        hcnt_d    = hcnt_q;
        z         = en && (hcnt_q == HIST_FULL) && (window == pattern_q);
        if (load) begin
            pattern_d = pat;
        end
        if (clr) begin
            hist_d = '0;
            hcnt_d = '0;
        end else if (en) begin
            hist_d = window[PAT_W-2:0];
            if (hcnt_q != HIST_FULL) begin
                hcnt_d = hcnt_q + HC_W'(1);
            end
        end
    end

    // Detector state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q <= '0;
            hist_q    <= '0;
            hcnt_q    <= '0;
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            hcnt_q    <= hcnt_d;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Parallel-to-serial scan controller feeding a programmable Mealy detector.
// Words are shifted LSB-first, one bit per clock; matches are counted with
// saturation. Define SEQ_SCAN_POS_EN to add first_pos/pos_valid outputs.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [PAT_W-1:0]            cfg_pattern,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W-1:0]           in_data,
    output logic                        busy,
    output logic                        z,
    output logic [CNT_W-1:0]            match_cnt,
    output logic                        done
`ifdef SEQ_SCAN_POS_EN
    ,
    output logic [$clog2(WORD_W)-1:0]   first_pos,
    output logic                        pos_valid
`endif
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(CNT_W));

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accept;
    logic                cfg_load;
    logic                shifting;
    logic                z_int;

    assign shifting  = (state_q == SHIFT);
    assign busy      = shifting;
    assign done      = (state_q == DONE);
    assign in_ready  = rst && (state_q == IDLE) && !cfg_we;
    assign z         = z_int;
    assign match_cnt = cnt_q;

    // Controller next state: accept/configure in IDLE, serialise in SHIFT, pulse DONE.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        accept    = 1'b0;
        cfg_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    cfg_load = 1'b1;
                end else if (in_valid) begin
                    accept    = 1'b1;
                    shift_d   = in_data;
                    bit_idx_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d   = shift_q >> 1;
                bit_idx_d = bit_idx_q + IDX_W'(1);
                if (bit_idx_q == LAST_IDX) begin
                    bit_idx_d = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating match counter, cleared by a pattern load.
    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (z_int && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
        end
    end

    pattern_mealy_fsm #(
        .PAT_W (PAT_W)
    ) u_det (
        .clk  (clk),
        .rst  (rst),
        .en   (shifting),
        .x    (shift_q[0]),
        .clr  (cfg_load),
        .load (cfg_load),
        .pat  (cfg_pattern),
        .z    (z_int)
    );

`ifdef SEQ_SCAN_POS_EN
    logic [IDX_W-1:0] first_pos_q;
    logic             pos_valid_q;

    // Capture the bit index of the first match in the current word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_pos_q <= '0;
            pos_valid_q <= 1'b0;
        end else if (accept || cfg_load) begin
            pos_valid_q <= 1'b0;
        end else if (z_int && !pos_valid_q) begin
            pos_valid_q <= 1'b1;
            first_pos_q <= bit_idx_q;
        end
    end

    assign first_pos = first_pos_q;
    assign pos_valid = pos_valid_q;
`endif

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Parallel-to-serial scan controller with an embedded programmable Mealy pattern detector.
- Accepts WORD_W-bit words over a valid/ready handshake and shifts each word LSB-first into the detector, one bit per clock.
- Counts overlapping pattern matches across the stream and signals word completion.
- Sits between a word-oriented producer and the serial sequence-detection logic; sequences and configures that logic.

Parameters:
WORD_W, 8, bits per input word
PAT_W, 3, pattern length in bits (2..8)
CNT_W, 8, match counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (asserted when 0)
cfg_we  in  1  pattern write strobe
cfg_pattern  in  PAT_W  new pattern; bit 0 = newest bit, bit PAT_W-1 = oldest
in_valid  in  1  input word valid
in_ready  out  1  controller can accept a word
in_data  in  WORD_W  input word
busy  out  1  shifting in progress
z  out  1  Mealy match pulse, combinational from state and current serial bit
match_cnt  out  CNT_W  saturating total match count
done  out  1  one-cycle pulse after the last bit of a word

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, shift reg=0, bit_idx=0, history=0, hist_cnt=0, pattern=0.
  - match_cnt=0, done=0, busy=0, z=0.
  - in_ready=1 once rst releases.
- Main FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = !cfg_we; busy=0.
  - cfg_we=1: load pattern, clear history, hist_cnt and match_cnt. Takes priority over in_valid; no word is accepted that cycle.
  - in_valid && in_ready: load shift reg <= in_data, bit_idx <= 0, go SHIFT.
- SHIFT:
  - busy=1, in_ready=0.
  - Serial bit x = shift_reg[0]; shift right, bit_idx++.
  - When bit_idx == WORD_W-1 this cycle, go DONE.
  - cfg_we is ignored.
- DONE: done=1 for exactly one cycle, busy=0, in_ready=0; go IDLE.
- Latency: word accepted at edge T; bits evaluated in cycles T+1..T+WORD_W; done high in cycle T+WORD_W+1. The next word can be accepted in cycle T+WORD_W+2. Throughput is one word per WORD_W+2 cycles.
- Detector:
  - Active only in SHIFT.
  - History h holds PAT_W-1 bits, newest in h[0]; update h <= {h[PAT_W-3:0], x}. hist_cnt saturates at PAT_W-1.
  - Match condition: z = SHIFT && hist_cnt == PAT_W-1 && {h, x} == pattern.
  - Overlapping matches count.
  - History persists across words and is cleared only by reset or cfg_we.
- match_cnt increments on every cycle with z=1 and saturates at 2^CNT_W-1; no wrap.
- Reset asserted mid-SHIFT aborts the word and clears everything, pattern included. No done is generated.
- in_data is sampled only on the accepting edge; later changes are ignored.

Optional Feature:
SEQ_SCAN_POS_EN
- Defined: adds outputs first_pos [$clog2(WORD_W)-1:0] and pos_valid.
  - first_pos = bit_idx of the first match within the current word.
  - pos_valid is set with that match, held through DONE, and cleared on the next word acceptance, cfg_we or reset.
- Not defined: ports absent; no position logic.

Decomposition:
- Package seq_scan_pkg holds:
  - state enum (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10);
  - default parameter constants;
  - the saturation max function.
- One sub-module: pattern_mealy_fsm. It holds pattern, history, hist_cnt and z, with inputs en, x, clr, load, pat.
- The controller FSM, shift register and counter stay in seq_scan_ctrl.

Test Plan:
- Pattern 3'b101, word 8'h15 (bits LSB-first 1,0,1,0,1,0,0,0) -> z high at bit_idx 2 and 4; match_cnt=2; done exactly 9 cycles after acceptance; first_pos=2 with SEQ_SCAN_POS_EN.
- Pattern 3'b001, word 8'h00 then word 8'h01 -> no match in word 1; z at word-2 bit_idx 0 (cross-word history); match_cnt=1.
- CNT_W=4, pattern 3'b111, words 8'hFF x3 -> match_cnt 6, then 14, then 15 held (saturation).
- cfg_we=1 and in_valid=1 together in IDLE -> in_ready=0, word not accepted, pattern loaded, match_cnt cleared; word accepted next cycle.
- rst=0 at bit_idx 3 of 8'hFF with pattern 3'b111 -> all outputs 0 immediately, no done; after release in_ready=1, pattern=0, history empty.
- cfg_we pulse during SHIFT -> ignored; pattern and match_cnt unchanged; word completes normally.
